mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences all data-memory traffic for the MEM/WB stage. Accepts one load/store per handshake from EX.
//  Drives a req/gnt + rvalid data-memory port with byte enables and lane-shifted write data.
//  Sign/zero-extends load data and issues a one-cycle WB write. Stalls the pipeline while busy.
// PARAMETERS
//  TIMEOUT   16  max cycles in WAIT_R before abandoning a load (>=2, counter width $clog2(TIMEOUT+1))
// PORTS
//  clk           in   1   clock, all logic on posedge
//  rst_n         in   1   reset, synchronous, active-low
//  ex_valid      in   1   EX presents a memory op
//  ex_ready      out  1   op accepted this cycle (ex_valid & ex_ready)
//  ex_is_store   in   1   1=store, 0=load
//  ex_funct3     in   3   RV32I width/sign code
//  ex_addr       in   32  byte address
//  ex_wdata      in   32  store data (rs2), low-aligned
//  ex_rd_idx     in   5   load destination register
//  dmem_req      out  1   request valid; held with addr/we/be/wdata stable until dmem_gnt
//  dmem_gnt      in   1   request accepted
//  dmem_we       out  1   1=write
//  dmem_be       out  4   byte enables (store lanes; 4'hF on loads)
//  dmem_addr     out  32  {ex_addr[31:2],2'b00}
//  dmem_wdata    out  32  store data shifted to byte lane
//  dmem_rvalid   in   1   read data valid
//  dmem_rdata    in   32  read word
//  wb_valid      out  1   one-cycle WB write strobe
//  wb_rd_idx     out  5   WB destination
//  wb_data       out  32  extended load result
//  stall         out  1   = state != IDLE
//  misalign_err  out  1   one-cycle pulse: misaligned or illegal funct3, op dropped
//  timeout_err   out  1   one-cycle pulse: load abandoned after TIMEOUT
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; every output register 0; dmem_req=0 immediately, even mid-transfer;
//   in-flight op discarded, a late dmem_rvalid after reset is ignored.
//  funct3: LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010; any other code is illegal.
//  Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
//  IDLE: ex_ready=1. On accept: illegal/misaligned -> misalign_err pulse next cycle, stay IDLE, no dmem access;
//   else latch op -> REQ.
//  REQ: dmem_req=1. On dmem_gnt: store -> IDLE (store complete, no wb_valid); load -> WAIT_R, clear counter.
//   dmem_rvalid in REQ is ignored.
//  WAIT_R: counter++ each cycle. On dmem_rvalid: register extended data; wb_valid=1 next cycle -> IDLE.
//   Counter reaches TIMEOUT without rvalid -> timeout_err pulse, -> IDLE, no wb_valid.
//  Load extract: byte lane = addr[1:0]; half lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
//  Store: SB be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}};
//   SW be=4'hF.
//  Min load latency: accept cyc0, REQ+gnt cyc1, rvalid cyc2, wb_valid cyc3. Min store: accept cyc0, gnt cyc1.
//  wb_valid, misalign_err and timeout_err are mutually exclusive and 1 cycle wide. wb_rd_idx/wb_data hold
//   between strobes. Loads to x0 still complete the bus transfer; wb_valid is suppressed when rd=0.
//  Next op is accepted only in IDLE (the cycle after completion); no overlap.
// STRUCTURE
//  mem_pkg: funct3 localparams (LB..LHU, SB..SW), typedef enum logic [1:0] {IDLE,REQ,WAIT_R} mac_state_e.
//  Sub-module load_align_ext (comb): funct3 + addr[1:0] + rdata -> 32b result.
//  Top: FSM, op latch, timeout counter, store lane/be logic, output regs.
// TESTING
//  1 LB addr=0x103, rdata=0x80FF_FF12, gnt cyc1, rvalid cyc2 -> wb_valid cyc3, wb_data=0xFFFF_FF80.
//  2 LHU addr=0x202, rdata=0x9ABC_1234 -> wb_data=0x0000_9ABC. LW 0x204 rdata=0xDEAD_BEEF -> 0xDEAD_BEEF.
//  3 SB addr=0x1, wdata=0x0000_00A5, gnt delayed 3 cyc -> req/addr=0x0/be=0010/wdata=0xA5A5_A5A5 held stable
//    through the wait; stall=1 until gnt; no wb_valid.
//  4 LW addr=0x6 -> misalign_err 1 cycle, dmem_req stays 0. funct3=011 load -> misalign_err.
//  5 Load, rvalid never returns (TIMEOUT=16) -> timeout_err after 16 WAIT_R cycles, IDLE, ex_ready=1.
//  6 rst_n=0 while in WAIT_R -> next cycle all outputs 0, IDLE; rvalid arriving afterwards -> no wb_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM/WB data-memory access controller.
// Holds the RV32I load/store width codes, the controller state type and
// small helpers for op legality and store lane placement.
package mem_pkg;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mac_state_e;

  // True when funct3 is a legal code for the op kind and the address is naturally aligned.
  function automatic logic op_ok(input logic is_store, input logic [2:0] funct3,
                                 input logic [1:0] lo);
    logic legal;
    logic aligned;
    if (is_store) begin
      legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end else begin
      legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
              (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end
    case (funct3[1:0])
      2'b01:   aligned = !lo[0];
      2'b10:   aligned = (lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

  // Byte enables for a legal store.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      F3_SB:   return 4'b0001 << lo;
      F3_SH:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated so the active bytes sit on their enabled lanes.
  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_SB:   return {4{wdata[7:0]}};
      F3_SH:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Purpose: pick the addressed byte/half out of a read word and sign/zero-extend it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows inputs every cycle.
module load_align_ext
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by width-dependent extension
  always_comb begin
    byte_sel = rdata[8*lo +: 8];
    half_sel = lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Purpose: sequence one EX load/store at a time onto a req/gnt + rvalid data-memory port, then write back.
// Latency: load accept->wb_valid 3 cycles minimum; store accept->gnt 1 cycle minimum.
// Backpressure: ex_ready only in IDLE; dmem request held stable until dmem_gnt; loads abandoned after TIMEOUT.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd_idx,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_idx,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  mac_state_e    state;
  logic          op_is_store;
  logic [2:0]    op_funct3;
  logic [1:0]    op_lo;
  logic [4:0]    op_rd;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [31:0]   load_res;
  logic          accept_ok;

  assign ex_ready  = (state == IDLE);
  assign stall     = (state != IDLE);
  assign cnt_nxt   = cnt + CW'(1);
  assign accept_ok = op_ok(ex_is_store, ex_funct3, ex_addr[1:0]);

  load_align_ext u_load_align_ext (
    .funct3 (op_funct3),
    .lo     (op_lo),
    .rdata  (dmem_rdata),
    .result (load_res)
  );

  // Controller FSM: op latch, memory request, read wait with timeout, registered WB/error strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_is_store  <= 1'b0;
      op_funct3    <= 3'b000;
      op_lo        <= 2'b00;
      op_rd        <= 5'd0;
      cnt          <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_be      <= 4'h0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      wb_valid     <= 1'b0;
      wb_rd_idx    <= 5'd0;
      wb_data      <= 32'h0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!accept_ok) begin
              // Dropped without touching the memory port
              misalign_err <= 1'b1;
            end else begin
              op_is_store <= ex_is_store;
              op_funct3   <= ex_funct3;
              op_lo       <= ex_addr[1:0];
              op_rd       <= ex_rd_idx;
              dmem_req    <= 1'b1;
              dmem_we     <= ex_is_store;
              dmem_addr   <= {ex_addr[31:2], 2'b00};
              dmem_be     <= ex_is_store ? store_be(ex_funct3, ex_addr[1:0]) : 4'hF;
              dmem_wdata  <= ex_is_store ? store_wdata(ex_funct3, ex_wdata) : 32'h0;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (op_is_store) begin
              state <= IDLE;
            end else begin
              cnt   <= '0;
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            // x0 loads finish the bus transfer but never write back
            if (op_rd != 5'd0) begin
              wb_valid  <= 1'b1;
              wb_rd_idx <= op_rd;
              wb_data   <= load_res;
            end
            state <= IDLE;
          end else if (cnt_nxt == TO_VAL) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
